// File: rtl/j1_boot_loader.sv
// j1_boot_loader: UART byte-stream loader for the j1a code/data RAM.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, LEN little-endian 16-bit words, CSUM.
// Words are written sequentially from address 0. The j1 is held in reset
// until a complete frame has been accepted.
// Optional feature: define BOOT_CHECKSUM_EN to compare CSUM against the XOR
// of every byte after SYNC. Without it the CSUM byte is consumed unchecked.
//
// Handshake: rx_valid is a single-cycle strobe and rx_data is only looked
// at in that cycle; there is no back-pressure. mem_wr is a single-cycle
// strobe with mem_addr/mem_dout valid in the same cycle.
//
// dbg_state encoding: 0 WAIT_SYNC, 1 LEN_LO, 2 LEN_HI, 3 DATA_LO,
// 4 DATA_HI, 5 CSUM, 6 RUN, 7 ERR.
module j1_boot_loader #(
  parameter int          LOG2ABITS      = 12,
  parameter int          DWIDTH         = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 boot_req,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 mem_wr,
  output logic [LOG2ABITS-1:0] mem_addr,
  output logic [DWIDTH-1:0]    mem_dout,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 boot_err,
  output logic [LOG2ABITS:0]   words_loaded,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_LO    = 3'd1,
    S_LEN_HI    = 3'd2,
    S_DATA_LO   = 3'd3,
    S_DATA_HI   = 3'd4,
    S_CSUM      = 3'd5,
    S_RUN       = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int                  TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]       TMO_ONE  = TW'(1);
  localparam logic [16:0]         MAX_LEN  = 17'(2 ** LOG2ABITS);
  localparam logic [LOG2ABITS:0]  WL_ONE   = (LOG2ABITS + 1)'(1);

  state_t                 state_q;
  logic                   mem_wr_q;
  logic [LOG2ABITS-1:0]   mem_addr_q;
  logic [DWIDTH-1:0]      mem_dout_q;
  logic                   cpu_reset_q;
  logic                   busy_q;
  logic                   boot_err_q;
  logic [LOG2ABITS:0]     words_q;
  logic [7:0]             len_lo_q;
  logic [15:0]            len_q;
  logic [7:0]             data_lo_q;
  logic [TW-1:0]          tmo_q;

  logic [15:0]            len_d;
  logic                   len_too_big;
  logic [LOG2ABITS:0]     words_d;
  logic                   last_word;
  logic                   tmo_expired;
  logic                   csum_ok;

  assign len_d       = {rx_data, len_lo_q};
  assign len_too_big = {1'b0, len_d} > MAX_LEN;
  assign words_d     = words_q + WL_ONE;
  assign last_word   = 32'(words_d) == 32'(len_q);
  assign tmo_expired = busy_q && !rx_valid && (tmo_q == TMO_LAST);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every byte after SYNC, restarted on each accepted SYNC.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (rx_valid && !boot_req) begin
      if (state_q == S_WAIT_SYNC && rx_data == SYNC_BYTE) begin
        csum_q <= 8'h00;
      end else if (state_q == S_LEN_LO || state_q == S_LEN_HI ||
                   state_q == S_DATA_LO || state_q == S_DATA_HI) begin
        csum_q <= csum_q ^ rx_data;
      end
    end
  end

  assign csum_ok = (rx_data == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_SYNC;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      boot_err_q  <= 1'b0;
      words_q     <= '0;
      len_lo_q    <= 8'h00;
      len_q       <= 16'h0000;
      data_lo_q   <= 8'h00;
      tmo_q       <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      if (boot_req) begin
        // Abort whatever is going on and wait for a fresh frame.
        state_q     <= S_WAIT_SYNC;
        cpu_reset_q <= 1'b1;
        boot_err_q  <= 1'b0;
        busy_q      <= 1'b0;
        words_q     <= '0;
        tmo_q       <= '0;
      end else if (tmo_expired) begin
        // Sender stalled mid-frame; words already written stay in RAM.
        state_q    <= S_ERR;
        boot_err_q <= 1'b1;
        busy_q     <= 1'b0;
        tmo_q      <= '0;
      end else begin
        if (rx_valid || !busy_q) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_ONE;
        end
        if (rx_valid) begin
          case (state_q)
            S_WAIT_SYNC: begin
              if (rx_data == SYNC_BYTE) begin
                state_q <= S_LEN_LO;
                busy_q  <= 1'b1;
              end
            end
            S_LEN_LO: begin
              len_lo_q <= rx_data;
              state_q  <= S_LEN_HI;
            end
            S_LEN_HI: begin
              len_q      <= len_d;
              words_q    <= '0;
              mem_addr_q <= '0;
              if (len_too_big) begin
                state_q    <= S_ERR;
                boot_err_q <= 1'b1;
                busy_q     <= 1'b0;
              end else if (len_d == 16'h0000) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA_LO;
              end
            end
            S_DATA_LO: begin
              data_lo_q <= rx_data;
              state_q   <= S_DATA_HI;
            end
            S_DATA_HI: begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= {rx_data, data_lo_q};
              mem_addr_q <= words_q[LOG2ABITS-1:0];
              words_q    <= words_d;
              state_q    <= last_word ? S_CSUM : S_DATA_LO;
            end
            S_CSUM: begin
              busy_q <= 1'b0;
              if (csum_ok) begin
                state_q     <= S_RUN;
                cpu_reset_q <= 1'b0;
              end else begin
                state_q    <= S_ERR;
                boot_err_q <= 1'b1;
              end
            end
            default: begin
              // RUN and ERR ignore the UART.
            end
          endcase
        end
      end
    end
  end

  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_dout     = mem_dout_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign boot_err     = boot_err_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Testbench for j1_boot_loader: directed frames from the test plan plus
// randomized frames, with a write scoreboard fed by a frame-level model.
module tb_j1_boot_loader;

  localparam int LOG2ABITS = 12;
  localparam int TMO       = 40;
  localparam int MAX_WORDS = 2 ** LOG2ABITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 boot_req = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 mem_wr;
  logic [LOG2ABITS-1:0] mem_addr;
  logic [15:0]          mem_dout;
  logic                 cpu_reset;
  logic                 busy;
  logic                 boot_err;
  logic [LOG2ABITS:0]   words_loaded;
  logic [2:0]           dbg_state;

  j1_boot_loader #(
    .LOG2ABITS(LOG2ABITS),
    .DWIDTH(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boot_req(boot_req),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .boot_err(boot_err),
    .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [27:0] exp_q[$];   // {addr[11:0], data[15:0]}
  logic [15:0] dat[$];     // payload of the next frame

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && mem_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {4'h0, mem_addr, mem_dout}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", {4'h0, mem_addr, mem_dout}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_boot_req();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  // Strobe one byte, then leave `gap` idle cycles. Returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    repeat (gap) @(negedge clk);
  endtask

  // Build a frame from dat[], predict its writes and outcome, send it.
  task automatic send_frame(input logic [15:0] len, input bit bad_csum, input int gap_max);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    bit overflow;
    bit expect_run;
    overflow = (int'(len) > MAX_WORDS);
    bytes.push_back(len[7:0]);
    bytes.push_back(len[15:8]);
    if (!overflow) begin
      for (int i = 0; i < int'(len); i++) begin
        bytes.push_back(dat[i][7:0]);
        bytes.push_back(dat[i][15:8]);
        exp_q.push_back({12'(i), dat[i]});
      end
    end
    cs = 8'h00;
    foreach (bytes[i]) cs = cs ^ bytes[i];
    if (bad_csum) cs = cs ^ 8'h01;
`ifdef BOOT_CHECKSUM_EN
    expect_run = !overflow && !bad_csum;
`else
    expect_run = !overflow;
`endif
    send_byte(8'hA5, $urandom_range(1, gap_max));
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], (overflow && i == 1) ? 0 : $urandom_range(1, gap_max));
    end
    if (overflow) begin
      check("ovf_err", {31'd0, boot_err}, 32'd1);
      check("ovf_busy", {31'd0, busy}, 32'd0);
      check("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end else begin
      check("pre_csum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      send_byte(cs, 0);
      check("post_csum_cpu_reset", {31'd0, cpu_reset}, {31'd0, !expect_run});
      check("post_csum_err", {31'd0, boot_err}, {31'd0, !expect_run});
      check("post_csum_busy", {31'd0, busy}, 32'd0);
      check("words_loaded", 32'(words_loaded), 32'(len));
    end
    @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_boot_err", {31'd0, boot_err}, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Reference frame: A5 02 00 34 12 78 56 0A
    dat = '{16'h1234, 16'h5678};
    send_frame(16'd2, 1'b0, 3);

    // In RUN, bytes (even SYNC) belong to the CPU.
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    check("run_ignores_rx_busy", {31'd0, busy}, 32'd0);
    check("run_ignores_rx_cpu", {31'd0, cpu_reset}, 32'd0);

    // Same frame with a bad checksum.
    pulse_boot_req();
    check("breq_clears_words", 32'(words_loaded), 32'd0);
    dat = '{16'h1234, 16'h5678};
    send_frame(16'd2, 1'b1, 3);

    // LEN one past the RAM size.
    pulse_boot_req();
    check("breq_clears_err", {31'd0, boot_err}, 32'd0);
    send_frame(16'd4097, 1'b0, 2);
    send_byte(8'hA5, 2);
    check("err_ignores_sync", {31'd0, busy}, 32'd0);

    // Zero-length frame.
    pulse_boot_req();
    send_frame(16'd0, 1'b0, 2);

    // boot_req together with SYNC while in RUN: boot_req wins.
    @(negedge clk);
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    boot_req = 1'b0;
    rx_valid = 1'b0;
    check("breq_vs_rx_cpu", {31'd0, cpu_reset}, 32'd1);
    check("breq_vs_rx_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    check("breq_vs_rx_busy", {31'd0, busy}, 32'd0);
    dat = '{16'hBEEF, 16'hA5A5, 16'h0102};
    send_frame(16'd3, 1'b0, 2);

    // Timeout: A5 03 00 11 22 then silence.
    pulse_boot_req();
    exp_q.push_back({12'd0, 16'h2211});
    send_byte(8'hA5, 2);
    send_byte(8'h03, 2);
    send_byte(8'h00, 2);
    send_byte(8'h11, 2);
    send_byte(8'h22, 0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet_busy", {31'd0, busy}, 32'd1);
    check("tmo_not_yet_err", {31'd0, boot_err}, 32'd0);
    repeat (4) @(negedge clk);
    check("tmo_err", {31'd0, boot_err}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("tmo_words", 32'(words_loaded), 32'd1);
    check("tmo_writes", exp_q.size(), 32'd0);

    // Randomized frames with noise before SYNC and SYNC-valued data bytes.
    for (int f = 0; f < 8; f++) begin
      int len;
      logic [7:0] noise;
      pulse_boot_req();
      repeat ($urandom_range(0, 3)) begin
        noise = $urandom_range(0, 255);
        if (noise == 8'hA5) noise = 8'h5A;
        send_byte(noise, $urandom_range(1, 3));
      end
      check("noise_ignored", {31'd0, busy}, 32'd0);
      len = $urandom_range(1, 8);
      dat.delete();
      for (int i = 0; i < len; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[7:0] = 8'hA5;
        dat.push_back(w);
      end
      send_frame(16'(len), ($urandom_range(0, 3) == 0), 4);
    end

    // Largest legal image fills every address.
    pulse_boot_req();
    dat.delete();
    for (int i = 0; i < MAX_WORDS; i++) dat.push_back(16'($urandom));
    send_frame(16'(MAX_WORDS), 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
